// File: rtl/io_bamse_gen_pkg.sv
// Shared definitions for io_bamse_gen: register offsets (relative to BASE),
// flag bit positions and the timer control register layout.
package io_bamse_gen_pkg;

  localparam logic [7:0] IO_IN     = 8'h00;  // + input port index, read-only
  localparam logic [7:0] IO_OUT    = 8'h10;  // + output latch index
  localparam logic [7:0] IO_MASK   = 8'h20;  // + input port index
  localparam logic [7:0] IO_FLAGS  = 8'h30;  // read; write-1-to-clear
  localparam logic [7:0] IO_IEN    = 8'h31;
  localparam logic [7:0] IO_RLD_LO = 8'h32;
  localparam logic [7:0] IO_RLD_HI = 8'h33;
  localparam logic [7:0] IO_TCTL   = 8'h34;
  localparam logic [7:0] IO_CNT_LO = 8'h35;  // live counter, read-only
  localparam logic [7:0] IO_CNT_HI = 8'h36;  // live counter, read-only

  localparam int IO_FLAG_TMR = 7;

  // Timer control: bit0 EN, bit1 AUTO (reload on expiry)
  typedef struct packed {
    logic auto_rld;
    logic en;
  } tctl_t;

endpackage

// File: rtl/io_bamse_gen_timer.sv
// pb_timer16: 16-bit down counter with reload.
//   load   - CNT <= rld (takes priority over counting)
//   en     - count enable (already gated off by the parent during a TCTL write)
//   auto   - on expiry reload from rld, otherwise request EN clear and hold 0
//   cnt    - live counter value
//   expire - one-cycle pulse while CNT==0 and running
//   en_clr - asks the parent to drop EN (one-shot finished)
module pb_timer16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic        auto,
  input  logic [15:0] rld,
  output logic [15:0] cnt,
  output logic        expire,
  output logic        en_clr
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    en_clr = 1'b0;
    if (load) begin
      cnt_d = rld;
    end else if (en) begin
      if (cnt_q == 16'd0) begin
        expire = 1'b1;
        if (auto) cnt_d = rld;
        else      en_clr = 1'b1;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/io_bamse_gen.sv
// io_bamse_gen: parametrised PacoBlaze I/O block.
//   port_in_pins  - N_IN raw async input ports, synchronised then edge-detected
//   port_out_pins - N_OUT output latches
//   port_id/port_in/wen - PacoBlaze write bus; port_out - registered read data
//   ren           - read strobe, reads have no side effects so it is unused
//   interrupt     - registered |(FLAGS & IEN); ioc_flags - current FLAGS
module io_bamse_gen
  import io_bamse_gen_pkg::*;
#(
  parameter int         N_IN  = 2,
  parameter int         N_OUT = 1,
  parameter int         W     = 8,
  parameter logic [7:0] BASE  = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_IN*W-1:0]  port_in_pins,
  output logic [N_OUT*W-1:0] port_out_pins,
  input  logic [7:0]         port_id,
  input  logic [W-1:0]       port_in,
  output logic [W-1:0]       port_out,
  input  logic               wen,
  input  logic               ren,
  output logic               interrupt,
  output logic [7:0]         ioc_flags
);

  logic unused_ren;
  assign unused_ren = ren;

  logic [7:0] off;
  assign off = port_id - BASE;

  // ---------------- register state ----------------
  logic [N_IN-1:0][W-1:0]  sync1_q, sync2_q, prev_q, mask_q;
  logic [N_OUT-1:0][W-1:0] out_q;
  logic [7:0]              flags_q, flags_d, ien_q;
  logic [15:0]             rld_q;
  tctl_t                   tctl_q, tctl_d;
  logic                    irq_q;
  logic [W-1:0]            rdata, port_out_q;

  // ---------------- decode / IOC ----------------
  logic [N_IN-1:0]  chg, wr_mask;
  logic [N_OUT-1:0] wr_out;
  logic             wr_flags, wr_ien, wr_rld_lo, wr_rld_hi, wr_tctl;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign chg[i]     = |((sync2_q[i] ^ prev_q[i]) & mask_q[i]);
    assign wr_mask[i] = wen && (off == IO_MASK + 8'(i));
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign wr_out[j] = wen && (off == IO_OUT + 8'(j));
  end

  assign wr_flags  = wen && (off == IO_FLAGS);
  assign wr_ien    = wen && (off == IO_IEN);
  assign wr_rld_lo = wen && (off == IO_RLD_LO);
  assign wr_rld_hi = wen && (off == IO_RLD_HI);
  assign wr_tctl   = wen && (off == IO_TCTL);

  // ---------------- timer ----------------
  logic [15:0] cnt;
  logic        tmr_exp, tmr_en_clr;

  // Gating EN off during any TCTL write makes "write EN=0" stop the count
  // in the write cycle itself, and a reload write never also expires.
  pb_timer16 u_tmr (
    .clk    (clk),
    .rst    (rst),
    .load   (wr_tctl && port_in[0]),
    .en     (tctl_q.en && !wr_tctl),
    .auto   (tctl_q.auto_rld),
    .rld    (rld_q),
    .cnt    (cnt),
    .expire (tmr_exp),
    .en_clr (tmr_en_clr)
  );

  always_comb begin
    tctl_d = tctl_q;
    if (wr_tctl) begin
      tctl_d.en       = port_in[0];
      tctl_d.auto_rld = port_in[1];
    end else if (tmr_en_clr) begin
      tctl_d.en = 1'b0;
    end
  end

  // ---------------- flags ----------------
  logic [7:0] set, clr;
  always_comb begin
    set              = '0;
    set[N_IN-1:0]    = chg;
    set[IO_FLAG_TMR] = tmr_exp;
    clr              = wr_flags ? port_in[7:0] : 8'h00;
    // A new event in the same cycle as its W1C is kept.
    flags_d          = (flags_q & ~clr) | set;
  end

  // ---------------- read mux ----------------
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (off == IO_IN   + 8'(i)) rdata = sync2_q[i];
      if (off == IO_MASK + 8'(i)) rdata = mask_q[i];
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (off == IO_OUT + 8'(j)) rdata = out_q[j];
    end
    case (off)
      IO_FLAGS:  rdata = W'(flags_q);
      IO_IEN:    rdata = W'(ien_q);
      IO_RLD_LO: rdata = W'(rld_q[7:0]);
      IO_RLD_HI: rdata = W'(rld_q[15:8]);
      IO_TCTL:   rdata = W'(tctl_q);
      IO_CNT_LO: rdata = W'(cnt[7:0]);
      IO_CNT_HI: rdata = W'(cnt[15:8]);
      default:   ;
    endcase
  end

  // ---------------- sequential ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      mask_q     <= '0;
      out_q      <= '0;
      flags_q    <= '0;
      ien_q      <= '0;
      rld_q      <= '0;
      tctl_q     <= '0;
      irq_q      <= 1'b0;
      port_out_q <= '0;
    end else begin
      sync1_q    <= port_in_pins;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      for (int i = 0; i < N_IN; i++)
        if (wr_mask[i]) mask_q[i] <= port_in;
      for (int j = 0; j < N_OUT; j++)
        if (wr_out[j]) out_q[j] <= port_in;
      flags_q    <= flags_d;
      if (wr_ien)    ien_q        <= port_in[7:0];
      if (wr_rld_lo) rld_q[7:0]   <= port_in[7:0];
      if (wr_rld_hi) rld_q[15:8]  <= port_in[7:0];
      tctl_q     <= tctl_d;
      irq_q      <= |(flags_q & ien_q);
      port_out_q <= rdata;
    end
  end

  assign port_out_pins = out_q;
  assign port_out      = port_out_q;
  assign interrupt     = irq_q;
  assign ioc_flags     = flags_q;

endmodule

// File: tb/tb_io_bamse_gen.sv
// Directed bench for io_bamse_gen (defaults N_IN=2, N_OUT=1, W=8, BASE=0).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_io_bamse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pins;
  logic [7:0]  pout;
  logic [7:0]  port_id, port_in, port_out, ioc_flags;
  logic        wen, ren, interrupt;
  logic [7:0]  r;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  io_bamse_gen dut (
    .clk           (clk),
    .rst           (rst),
    .port_in_pins  (pins),
    .port_out_pins (pout),
    .port_id       (port_id),
    .port_in       (port_in),
    .port_out      (port_out),
    .wen           (wen),
    .ren           (ren),
    .interrupt     (interrupt),
    .ioc_flags     (ioc_flags)
  );

  // Called on a falling edge; returns on the next falling edge after the write.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id = a; port_in = d; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    port_id = a; ren = 1'b1;
    @(negedge clk);
    ren = 1'b0;
    d = port_out;
  endtask

  task automatic test_reset;
    rst = 1'b1; wen = 1'b0; ren = 1'b0; port_id = 8'h00; port_in = 8'h00; pins = 16'h0000;
    repeat (2) @(negedge clk);
    checks++; if (pout !== 8'h00) begin failures++; $display("FAIL reset_pins got=%h exp=00", pout); end
    checks++; if (port_out !== 8'h00) begin failures++; $display("FAIL reset_port_out got=%h exp=00", port_out); end
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", interrupt); end
    checks++; if (ioc_flags !== 8'h00) begin failures++; $display("FAIL reset_flags got=%h exp=00", ioc_flags); end
    rst = 1'b0;
    rd(8'h30, r);
    checks++; if (r !== 8'h00) begin failures++; $display("FAIL reset_flags_read got=%h exp=00", r); end
  endtask

  task automatic test_ioc;
    wr(8'h21, 8'h04);
    wr(8'h31, 8'h02);
    pins[10] = 1'b1;                       // IN1 bit2 rises
    repeat (2) @(negedge clk);
    checks++; if (ioc_flags !== 8'h00) begin failures++; $display("FAIL ioc_early got=%h exp=00", ioc_flags); end
    @(negedge clk);
    checks++; if (ioc_flags !== 8'h02) begin failures++; $display("FAIL ioc_set3 got=%h exp=02", ioc_flags); end
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL ioc_irq_early got=%b exp=0", interrupt); end
    @(negedge clk);
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL ioc_irq got=%b exp=1", interrupt); end
    rd(8'h30, r);
    checks++; if (r !== 8'h02) begin failures++; $display("FAIL ioc_read got=%h exp=02", r); end
    checks++; if (ioc_flags !== 8'h02) begin failures++; $display("FAIL ioc_read_noclear got=%h exp=02", ioc_flags); end
    wr(8'h30, 8'h02);
    checks++; if (ioc_flags !== 8'h00) begin failures++; $display("FAIL ioc_w1c got=%h exp=00", ioc_flags); end
    @(negedge clk);
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL ioc_irq_drop got=%b exp=0", interrupt); end
    pins[11] = 1'b1; pins[0] = 1'b1;        // unmasked bits only
    repeat (5) @(negedge clk);
    checks++; if (ioc_flags !== 8'h00) begin failures++; $display("FAIL ioc_unmasked got=%h exp=00", ioc_flags); end
  endtask

  task automatic test_w1c_race;
    pins[10] = 1'b0;                       // falling edge also counts
    repeat (4) @(negedge clk);
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL race_pre_irq got=%b exp=1", interrupt); end
    pins[10] = 1'b1;
    repeat (2) @(negedge clk);
    port_id = 8'h30; port_in = 8'h02; wen = 1'b1;  // W1C lands on the set cycle
    @(negedge clk);
    wen = 1'b0;
    checks++; if (ioc_flags !== 8'h02) begin failures++; $display("FAIL race_flag got=%h exp=02", ioc_flags); end
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL race_irq got=%b exp=1", interrupt); end
    @(negedge clk);
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL race_irq_hold got=%b exp=1", interrupt); end
    wr(8'h30, 8'h02);
    checks++; if (ioc_flags !== 8'h00) begin failures++; $display("FAIL race_clear got=%h exp=00", ioc_flags); end
  endtask

  task automatic test_timer;
    wr(8'h32, 8'h04);
    wr(8'h33, 8'h00);
    wr(8'h34, 8'h03);                      // load CNT=4, auto
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (ioc_flags[7] !== 1'b0) begin failures++; $display("FAIL tmr_auto_early k=%0d got=%b exp=0", k, ioc_flags[7]); end
    end
    @(negedge clk);
    checks++; if (ioc_flags[7] !== 1'b1) begin failures++; $display("FAIL tmr_auto_exp1 got=%b exp=1", ioc_flags[7]); end
    wr(8'h30, 8'h80);
    checks++; if (ioc_flags[7] !== 1'b0) begin failures++; $display("FAIL tmr_w1c got=%b exp=0", ioc_flags[7]); end
    for (int k = 7; k <= 9; k++) begin
      @(negedge clk);
      checks++; if (ioc_flags[7] !== 1'b0) begin failures++; $display("FAIL tmr_auto_mid k=%0d got=%b exp=0", k, ioc_flags[7]); end
    end
    @(negedge clk);
    checks++; if (ioc_flags[7] !== 1'b1) begin failures++; $display("FAIL tmr_auto_exp2 got=%b exp=1", ioc_flags[7]); end
    wr(8'h34, 8'h00);                      // stop: CNT held at reloaded 4
    rd(8'h35, r);
    checks++; if (r !== 8'h04) begin failures++; $display("FAIL tmr_stop_cnt got=%h exp=04", r); end
    rd(8'h34, r);
    checks++; if (r !== 8'h00) begin failures++; $display("FAIL tmr_stop_tctl got=%h exp=00", r); end
    // one-shot
    wr(8'h30, 8'h80);
    wr(8'h34, 8'h01);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (ioc_flags[7] !== 1'b0) begin failures++; $display("FAIL tmr_one_early k=%0d got=%b exp=0", k, ioc_flags[7]); end
    end
    @(negedge clk);
    checks++; if (ioc_flags[7] !== 1'b1) begin failures++; $display("FAIL tmr_one_exp got=%b exp=1", ioc_flags[7]); end
    rd(8'h34, r);
    checks++; if (r !== 8'h00) begin failures++; $display("FAIL tmr_one_en got=%h exp=00", r); end
    rd(8'h35, r);
    checks++; if (r !== 8'h00) begin failures++; $display("FAIL tmr_one_cnt got=%h exp=00", r); end
    wr(8'h30, 8'h80);
    repeat (8) @(negedge clk);
    checks++; if (ioc_flags[7] !== 1'b0) begin failures++; $display("FAIL tmr_one_once got=%b exp=0", ioc_flags[7]); end
    // RLD=0: expires every cycle, so W1C cannot clear while running
    wr(8'h32, 8'h00);
    wr(8'h34, 8'h03);
    @(negedge clk);
    checks++; if (ioc_flags[7] !== 1'b1) begin failures++; $display("FAIL tmr_rld0_exp got=%b exp=1", ioc_flags[7]); end
    wr(8'h30, 8'h80);
    checks++; if (ioc_flags[7] !== 1'b1) begin failures++; $display("FAIL tmr_rld0_setwins got=%b exp=1", ioc_flags[7]); end
    wr(8'h34, 8'h00);
    wr(8'h30, 8'h80);
    checks++; if (ioc_flags[7] !== 1'b0) begin failures++; $display("FAIL tmr_rld0_clear got=%b exp=0", ioc_flags[7]); end
  endtask

  task automatic test_regs;
    checks++; if (pout !== 8'h00) begin failures++; $display("FAIL out_pre got=%h exp=00", pout); end
    wr(8'h10, 8'hA5);
    checks++; if (pout !== 8'hA5) begin failures++; $display("FAIL out_pins got=%h exp=a5", pout); end
    rd(8'h10, r);
    checks++; if (r !== 8'hA5) begin failures++; $display("FAIL out_read got=%h exp=a5", r); end
    rd(8'h7F, r);
    checks++; if (r !== 8'h00) begin failures++; $display("FAIL unmapped_read got=%h exp=00", r); end
    pins[7:0] = 8'h3C;
    repeat (2) @(negedge clk);
    rd(8'h00, r);
    checks++; if (r !== 8'h3C) begin failures++; $display("FAIL in0_read got=%h exp=3c", r); end
    wr(8'h00, 8'hFF);                      // RO write ignored
    rd(8'h00, r);
    checks++; if (r !== 8'h3C) begin failures++; $display("FAIL in0_ro got=%h exp=3c", r); end
    rd(8'h21, r);
    checks++; if (r !== 8'h04) begin failures++; $display("FAIL mask1_read got=%h exp=04", r); end
    rd(8'h31, r);
    checks++; if (r !== 8'h02) begin failures++; $display("FAIL ien_read got=%h exp=02", r); end
  endtask

  task automatic test_reset_mid;
    wr(8'h31, 8'h80);
    wr(8'h32, 8'h10);
    wr(8'h34, 8'h03);
    repeat (18) @(negedge clk);
    checks++; if (interrupt !== 1'b1) begin failures++; $display("FAIL mid_pre_irq got=%b exp=1", interrupt); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ioc_flags !== 8'h00) begin failures++; $display("FAIL mid_flags got=%h exp=00", ioc_flags); end
    checks++; if (interrupt !== 1'b0) begin failures++; $display("FAIL mid_irq got=%b exp=0", interrupt); end
    checks++; if (pout !== 8'h00) begin failures++; $display("FAIL mid_pins got=%h exp=00", pout); end
    rst = 1'b0;
    rd(8'h35, r);
    checks++; if (r !== 8'h00) begin failures++; $display("FAIL mid_cnt got=%h exp=00", r); end
    rd(8'h34, r);
    checks++; if (r !== 8'h00) begin failures++; $display("FAIL mid_tctl got=%h exp=00", r); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ioc();
    test_w1c_race();
    test_timer();
    test_regs();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
